// File: rtl/way_alloc_if.sv
// Handshake bundle between the miss/fill sequencer and
// the way allocation controller.
interface way_alloc_if #(
    parameter int NUM_WAYS   = 8,
    parameter int INDEX_BITS = 4
);
    logic                  alloc_req;
    logic [INDEX_BITS-1:0] alloc_index;
    logic                  alloc_ready;
    logic                  alloc_valid;
    logic [NUM_WAYS-1:0]   alloc_way;
    logic                  alloc_evict;
    logic                  inval_req;
    logic [INDEX_BITS-1:0] inval_index;
    logic [NUM_WAYS-1:0]   inval_way;
    logic                  flush_req;
    logic                  flush_busy;

    modport master (
        output alloc_req,
        output alloc_index,
        input  alloc_ready,
        input  alloc_valid,
        input  alloc_way,
        input  alloc_evict,
        output inval_req,
        output inval_index,
        output inval_way,
        output flush_req,
        input  flush_busy
    );

    modport slave (
        input  alloc_req,
        input  alloc_index,
        output alloc_ready,
        output alloc_valid,
        output alloc_way,
        output alloc_evict,
        input  inval_req,
        input  inval_index,
        input  inval_way,
        input  flush_req,
        output flush_busy
    );
endinterface

// File: rtl/way_alloc_ctrl.sv
// Per-set way allocator: lowest empty way first, round-robin
// victim once the set is full, with invalidate and flush.
module way_alloc_ctrl #(
    parameter int NUM_WAYS   = 8,
    parameter int INDEX_BITS = 4
) (
    input logic       clock,
    input logic       reset,
    way_alloc_if.slave bus
);
    localparam int NUM_SETS = 1 << INDEX_BITS;
    localparam int PTR_BITS = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        GRANT,
        FLUSH
    } state_t;

    state_t                state;
    logic [NUM_WAYS-1:0]   occ  [NUM_SETS];
    logic [PTR_BITS-1:0]   vptr [NUM_SETS];
    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fcnt;
    logic [NUM_WAYS-1:0]   way_q;
    logic                  evict_q;

    logic [NUM_WAYS-1:0]   cur_occ;
    logic [NUM_WAYS-1:0]   free_way;
    logic [NUM_WAYS-1:0]   pick_way;
    logic [NUM_WAYS-1:0]   inval_mask;
    logic                  set_full;
    logic                  inval_ok;

    assign bus.alloc_ready = (state == IDLE);
    assign bus.alloc_valid = (state == GRANT);
    assign bus.flush_busy  = (state == FLUSH);
    assign bus.alloc_way   = way_q;
    assign bus.alloc_evict = evict_q;

    // Way selection for the latched set, from pre-edge occupancy.
    always_comb begin
        cur_occ  = occ[idx];
        set_full = &cur_occ;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!cur_occ[i]) begin
                free_way    = '0;
                free_way[i] = 1'b1;
            end
        end
        if (set_full)
            pick_way = NUM_WAYS'(1) << vptr[idx];
        else
            pick_way = free_way;
        inval_ok = bus.inval_req && (state != FLUSH);
        if (inval_ok && (bus.inval_index == idx))
            inval_mask = bus.inval_way;
        else
            inval_mask = '0;
    end

    // Controller FSM, occupancy/victim state and grant registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            fcnt    <= '0;
            way_q   <= '0;
            evict_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                occ[s]  <= '0;
                vptr[s] <= '0;
            end
        end else begin
            if (inval_ok)
                occ[bus.inval_index] <=
                    occ[bus.inval_index] & ~bus.inval_way;
            unique case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        fcnt  <= '0;
                        state <= FLUSH;
                    end else if (bus.alloc_req) begin
                        idx   <= bus.alloc_index;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    way_q    <= pick_way;
                    evict_q  <= set_full;
                    // grant bit wins over a same-edge invalidate
                    occ[idx] <= (cur_occ & ~inval_mask) | pick_way;
                    if (set_full)
                        vptr[idx] <= vptr[idx] + 1'b1;
                    state <= GRANT;
                end
                GRANT: begin
                    state <= IDLE;
                end
                FLUSH: begin
                    occ[fcnt]  <= '0;
                    vptr[fcnt] <= '0;
                    fcnt       <= fcnt + 1'b1;
                    if (&fcnt)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Randomized self-checking bench for way_alloc_ctrl against
// a set/way occupancy reference model.
module tb_way_alloc_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;

    way_alloc_if #(.NUM_WAYS(8), .INDEX_BITS(4)) bus ();

    way_alloc_ctrl #(.NUM_WAYS(8), .INDEX_BITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    bit [7:0] occ_m  [16];
    int       vptr_m [16];

    function automatic void model_clear();
        for (int s = 0; s < 16; s++) begin
            occ_m[s]  = 8'h00;
            vptr_m[s] = 0;
        end
    endfunction

    function automatic void model_grant(input int s,
                                        output bit [7:0] w,
                                        output bit ev);
        bit found;
        found = 0;
        w     = 8'h00;
        ev    = 0;
        if (occ_m[s] != 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                if (!found && !occ_m[s][i]) begin
                    w     = 8'(1 << i);
                    found = 1;
                end
            end
        end else begin
            w         = 8'(1 << vptr_m[s]);
            vptr_m[s] = (vptr_m[s] + 1) % 8;
            ev        = 1;
        end
    endfunction

    // Starts and ends at a negedge with the DUT idle.
    task automatic do_alloc(input int s, input bit inv,
                            input int inv_set,
                            input bit [7:0] inv_mask,
                            input string tag);
        bit [7:0] w;
        bit       ev;
        checks++;
        if (bus.alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_pre: got %b want 1",
                     tag, bus.alloc_ready);
        end
        bus.alloc_req   = 1'b1;
        bus.alloc_index = 4'(s);
        @(posedge clock);
        #1 bus.alloc_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.alloc_ready !== 1'b0 || bus.alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s lookup: ready %b valid %b want 0 0",
                     tag, bus.alloc_ready, bus.alloc_valid);
        end
        if (inv) begin
            bus.inval_req   = 1'b1;
            bus.inval_index = 4'(inv_set);
            bus.inval_way   = inv_mask;
        end
        model_grant(s, w, ev);
        if (inv) occ_m[inv_set] = occ_m[inv_set] & ~inv_mask;
        occ_m[s] = occ_m[s] | w;
        @(posedge clock);
        #1 bus.inval_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: valid %b ready %b want 1 0",
                     tag, bus.alloc_valid, bus.alloc_ready);
        end
        checks++;
        if (bus.alloc_way !== w) begin
            errors++;
            $display("FAIL %s way: got %h want %h",
                     tag, bus.alloc_way, w);
        end
        checks++;
        if (bus.alloc_evict !== ev) begin
            errors++;
            $display("FAIL %s evict: got %b want %b",
                     tag, bus.alloc_evict, ev);
        end
        @(negedge clock);
        checks++;
        if (bus.alloc_ready !== 1'b1 || bus.alloc_valid !== 1'b0
            || bus.alloc_way !== w) begin
            errors++;
            $display("FAIL %s post: ready %b valid %b way %h want 1 0 %h",
                     tag, bus.alloc_ready, bus.alloc_valid,
                     bus.alloc_way, w);
        end
    endtask

    task automatic do_inval(input int s, input bit [7:0] mask);
        bus.inval_req   = 1'b1;
        bus.inval_index = 4'(s);
        bus.inval_way   = mask;
        @(posedge clock);
        #1 bus.inval_req = 1'b0;
        occ_m[s] = occ_m[s] & ~mask;
        @(negedge clock);
    endtask

    task automatic do_flush(input bit with_alloc,
                            input bit with_inval,
                            input string tag);
        int n;
        bit done;
        bus.flush_req   = 1'b1;
        bus.alloc_req   = with_alloc;
        bus.alloc_index = 4'd3;
        @(posedge clock);
        #1;
        bus.flush_req = 1'b0;
        bus.alloc_req = 1'b0;
        n    = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clock);
            bus.inval_req = 1'b0;
            if (!bus.flush_busy) begin
                done = 1;
            end else begin
                n++;
                checks++;
                if (bus.alloc_ready !== 1'b0
                    || bus.alloc_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy: ready %b valid %b want 0 0",
                             tag, bus.alloc_ready, bus.alloc_valid);
                end
                if (with_inval) begin
                    bus.inval_req   = 1'b1;
                    bus.inval_index = 4'($urandom_range(0, 15));
                    bus.inval_way   = 8'($urandom);
                end
            end
        end
        bus.inval_req = 1'b0;
        checks++;
        if (n != 16 || !done) begin
            errors++;
            $display("FAIL %s length: got %0d cycles want 16",
                     tag, n);
        end
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (bus.alloc_ready !== 1'b1 || bus.alloc_valid !== 1'b0
            || bus.alloc_way !== 8'h00 || bus.alloc_evict !== 1'b0
            || bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy %b vld %b way %h ev %b busy %b",
                     bus.alloc_ready, bus.alloc_valid, bus.alloc_way,
                     bus.alloc_evict, bus.flush_busy);
        end
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        @(negedge clock);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++)
            do_alloc(3, 0, 0, 8'h00, "fill");
    endtask

    task automatic test_round_robin();
        do_alloc(3, 0, 0, 8'h00, "rr9");
        do_alloc(3, 0, 0, 8'h00, "rr10");
        for (int i = 0; i < 9; i++)
            do_alloc(5, 0, 0, 8'h00, "rr_set5");
    endtask

    task automatic test_invalidate();
        for (int i = 0; i < 8; i++)
            do_alloc(2, 0, 0, 8'h00, "inv_fill");
        do_inval(2, 8'h8D);
        do_alloc(2, 1, 2, 8'h01, "inv_lookup");
        do_alloc(2, 0, 0, 8'h00, "inv_next");
        do_alloc(2, 0, 0, 8'h00, "inv_bit0");
    endtask

    task automatic test_flush_priority();
        do_flush(1, 0, "flush_pri");
        for (int i = 0; i < 9; i++)
            do_alloc(3, 0, 0, 8'h00, "post_flush");
    endtask

    task automatic test_inval_during_flush();
        for (int i = 0; i < 3; i++)
            do_alloc(9, 0, 0, 8'h00, "pre_flush");
        do_flush(0, 1, "flush_inv");
        for (int s = 0; s < 16; s++)
            do_alloc(s, 0, 0, 8'h00, "empty_chk");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++)
            do_alloc(7, 0, 0, 8'h00, "rm_fill");
        bus.alloc_req   = 1'b1;
        bus.alloc_index = 4'd7;
        @(posedge clock);
        #1 bus.alloc_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (bus.alloc_ready !== 1'b1 || bus.alloc_valid !== 1'b0
            || bus.alloc_way !== 8'h00 || bus.alloc_evict !== 1'b0
            || bus.flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy %b vld %b way %h ev %b bsy %b",
                     bus.alloc_ready, bus.alloc_valid, bus.alloc_way,
                     bus.alloc_evict, bus.flush_busy);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (bus.alloc_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold valid: got %b want 0",
                         bus.alloc_valid);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        do_alloc(7, 0, 0, 8'h00, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)
                do_inval($urandom_range(0, 3), 8'($urandom));
            else
                do_alloc($urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0),
                         $urandom_range(0, 3),
                         8'($urandom), "random");
        end
    endtask

    initial begin
        bus.alloc_req   = 1'b0;
        bus.alloc_index = '0;
        bus.inval_req   = 1'b0;
        bus.inval_index = '0;
        bus.inval_way   = '0;
        bus.flush_req   = 1'b0;
        test_reset();
        test_fill();
        test_round_robin();
        test_invalidate();
        test_flush_priority();
        test_inval_during_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
